// File: rtl/select_encode_unit.sv
// ============================================================================
// Module   : select_encode_unit
// Brief    : IR capture, Ra/Rb/Rc select-encode to one-hot register enables,
//            C-constant sign extension and bus-source conflict monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module select_encode_unit #(
    parameter int NREG = 16,
    parameter int DW   = 32,
    parameter int CW   = 19,
    parameter int CNTW = 8
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [DW-1:0]   ir_in,
    input  logic            ir_load,
    input  logic            gra,
    input  logic            grb,
    input  logic            grc,
    input  logic            r_in,
    input  logic            r_out,
    input  logic            ba_out,
    input  logic [DW-1:0]   bus_src,
    input  logic            err_clr,
    output logic [DW-1:0]   ir_q,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_out,
    output logic            r0_zero,
    output logic [DW-1:0]   c_sign,
    output logic [3:0]      field_idx,
    output logic            bus_conflict,
    output logic [DW-1:0]   conflict_src,
    output logic [CNTW-1:0] conflict_cnt
);

    // Bus-source bits at and above this index have no driver assigned.
    localparam int c_NSRC = 24;

    logic [3:0]      w_idx;
    logic            w_any_gr;
    logic [NREG-1:0] w_sel;
    logic            w_r0_sel;
    logic [NREG-1:0] w_reg_in_nxt;
    logic [NREG-1:0] w_reg_out_nxt;
    logic            w_multi;
    logic            w_unassigned;
    logic            w_illegal;

    // Decode always reads the IR as it stands before this edge's load.
    always_comb begin
        w_idx = 4'd0;
        if (gra)
            w_idx = ir_q[26:23];
        else if (grb)
            w_idx = ir_q[22:19];
        else if (grc)
            w_idx = ir_q[18:15];
    end

    assign w_any_gr = gra | grb | grc;
    assign w_sel    = NREG'(1) << w_idx;
    assign w_r0_sel = ba_out & w_any_gr & (w_idx == 4'd0);

    always_comb begin
        w_reg_in_nxt  = (r_in & w_any_gr) ? w_sel : '0;
        w_reg_out_nxt = ((r_out | ba_out) & w_any_gr) ? w_sel : '0;
        // Base-address use of R0 reads constant zero instead of driving R0.
        if (w_r0_sel)
            w_reg_out_nxt[0] = 1'b0;
    end

    assign w_multi      = (bus_src & (bus_src - DW'(1))) != '0;
    assign w_unassigned = bus_src[DW-1:c_NSRC] != '0;
    assign w_illegal    = w_multi | w_unassigned;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            ir_q      <= '0;
            reg_in    <= '0;
            reg_out   <= '0;
            r0_zero   <= 1'b0;
            c_sign    <= '0;
            field_idx <= 4'd0;
        end else begin
            if (ir_load)
                ir_q <= ir_in;
            reg_in    <= w_reg_in_nxt;
            reg_out   <= w_reg_out_nxt;
            r0_zero   <= w_r0_sel;
            field_idx <= w_idx;
            c_sign    <= {{(DW-CW){ir_q[CW-1]}}, ir_q[CW-1:0]};
        end
    end

    // A clear coinciding with a new offence restarts the record from that offence.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_conflict <= 1'b0;
            conflict_src <= '0;
            conflict_cnt <= '0;
        end else if (w_illegal) begin
            bus_conflict <= 1'b1;
            if (!bus_conflict || err_clr)
                conflict_src <= bus_src;
            if (err_clr)
                conflict_cnt <= CNTW'(1);
            else if (!(&conflict_cnt))
                conflict_cnt <= conflict_cnt + CNTW'(1);
        end else if (err_clr) begin
            bus_conflict <= 1'b0;
            conflict_src <= '0;
            conflict_cnt <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_select_encode_unit.sv
// ============================================================================
// Module   : tb_select_encode_unit
// Brief    : Directed, table-driven self-checking bench for select_encode_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_select_encode_unit;

    logic        clock;
    logic        clear;
    logic [31:0] ir_in;
    logic        ir_load;
    logic        gra, grb, grc;
    logic        r_in, r_out, ba_out;
    logic [31:0] bus_src;
    logic        err_clr;
    logic [31:0] ir_q;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        r0_zero;
    logic [31:0] c_sign;
    logic [3:0]  field_idx;
    logic        bus_conflict;
    logic [31:0] conflict_src;
    logic [7:0]  conflict_cnt;

    int checks;
    int failures;

    select_encode_unit #(
        .NREG (16),
        .DW   (32),
        .CW   (19),
        .CNTW (8)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .ir_in        (ir_in),
        .ir_load      (ir_load),
        .gra          (gra),
        .grb          (grb),
        .grc          (grc),
        .r_in         (r_in),
        .r_out        (r_out),
        .ba_out       (ba_out),
        .bus_src      (bus_src),
        .err_clr      (err_clr),
        .ir_q         (ir_q),
        .reg_in       (reg_in),
        .reg_out      (reg_out),
        .r0_zero      (r0_zero),
        .c_sign       (c_sign),
        .field_idx    (field_idx),
        .bus_conflict (bus_conflict),
        .conflict_src (conflict_src),
        .conflict_cnt (conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        ld;
        logic [31:0] din;
        logic        ga, gb, gc, ri, ro, ba;
        logic [15:0] e_in;
        logic [15:0] e_out;
        logic [3:0]  e_idx;
        logic        e_r0;
        logic [31:0] e_ir;
        logic [31:0] e_cs;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_ctrl();
        ir_load = 1'b0; ir_in = '0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0;
        r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ir_q"},      ir_q, 32'h0);
        chk({tag, ".reg_in"},    32'(reg_in), 32'h0);
        chk({tag, ".reg_out"},   32'(reg_out), 32'h0);
        chk({tag, ".r0_zero"},   32'(r0_zero), 32'h0);
        chk({tag, ".c_sign"},    c_sign, 32'h0);
        chk({tag, ".field_idx"}, 32'(field_idx), 32'h0);
        chk({tag, ".flag"},      32'(bus_conflict), 32'h0);
        chk({tag, ".src"},       conflict_src, 32'h0);
        chk({tag, ".cnt"},       32'(conflict_cnt), 32'h0);
    endtask

    initial begin
        checks = 0;
        failures = 0;

        //        ld  din           ga grb grc ri ro ba  e_in     e_out    idx   r0  e_ir          e_cs
        tbl[0]  = '{1'b1, 32'h0A9B8000, 0,0,0, 0,0,0, 16'h0000, 16'h0000, 4'd0, 0, 32'h0A9B8000, 32'h00000000};
        tbl[1]  = '{1'b0, 32'h00000000, 1,0,0, 1,0,0, 16'h0020, 16'h0000, 4'd5, 0, 32'h0A9B8000, 32'h00038000};
        tbl[2]  = '{1'b0, 32'h00000000, 0,1,0, 0,1,0, 16'h0000, 16'h0008, 4'd3, 0, 32'h0A9B8000, 32'h00038000};
        tbl[3]  = '{1'b0, 32'h00000000, 0,0,1, 0,0,0, 16'h0000, 16'h0000, 4'd7, 0, 32'h0A9B8000, 32'h00038000};
        tbl[4]  = '{1'b0, 32'h00000000, 1,1,0, 1,0,0, 16'h0020, 16'h0000, 4'd5, 0, 32'h0A9B8000, 32'h00038000};
        tbl[5]  = '{1'b0, 32'h00000000, 0,1,0, 1,1,0, 16'h0008, 16'h0008, 4'd3, 0, 32'h0A9B8000, 32'h00038000};
        tbl[6]  = '{1'b0, 32'h00000000, 0,0,0, 1,1,0, 16'h0000, 16'h0000, 4'd0, 0, 32'h0A9B8000, 32'h00038000};
        tbl[7]  = '{1'b1, 32'h00040000, 0,0,0, 0,0,0, 16'h0000, 16'h0000, 4'd0, 0, 32'h00040000, 32'h00038000};
        tbl[8]  = '{1'b0, 32'h00000000, 1,0,0, 0,1,1, 16'h0000, 16'h0000, 4'd0, 1, 32'h00040000, 32'hFFFC0000};
        tbl[9]  = '{1'b0, 32'h00000000, 1,0,0, 0,1,0, 16'h0000, 16'h0001, 4'd0, 0, 32'h00040000, 32'hFFFC0000};
        tbl[10] = '{1'b0, 32'h00000000, 0,0,1, 0,0,1, 16'h0000, 16'h0100, 4'd8, 0, 32'h00040000, 32'hFFFC0000};
        tbl[11] = '{1'b0, 32'h00000000, 1,0,0, 1,0,1, 16'h0001, 16'h0000, 4'd0, 1, 32'h00040000, 32'hFFFC0000};

        idle_ctrl();
        bus_src = '0;
        err_clr = 1'b0;
        clear   = 1'b0;
        #12;
        chk_all_zero("reset");
        clear = 1'b1;
        tick();

        // Table-driven decode vectors, one clock each.
        for (int i = 0; i < 12; i++) begin
            ir_load = tbl[i].ld; ir_in = tbl[i].din;
            gra = tbl[i].ga; grb = tbl[i].gb; grc = tbl[i].gc;
            r_in = tbl[i].ri; r_out = tbl[i].ro; ba_out = tbl[i].ba;
            tick();
            chk($sformatf("v%0d.reg_in", i),    32'(reg_in),    32'(tbl[i].e_in));
            chk($sformatf("v%0d.reg_out", i),   32'(reg_out),   32'(tbl[i].e_out));
            chk($sformatf("v%0d.field_idx", i), 32'(field_idx), 32'(tbl[i].e_idx));
            chk($sformatf("v%0d.r0_zero", i),   32'(r0_zero),   32'(tbl[i].e_r0));
            chk($sformatf("v%0d.ir_q", i),      ir_q,           tbl[i].e_ir);
            chk($sformatf("v%0d.c_sign", i),    c_sign,         tbl[i].e_cs);
        end
        idle_ctrl();

        // Load collides with decode: old Ra (5) is used, then new Ra (2).
        ir_load = 1'b1; ir_in = 32'h0A9B8000;
        tick();
        ir_in = 32'h01000000; gra = 1'b1; r_in = 1'b1;
        tick();
        chk("preload.reg_in", 32'(reg_in), 32'h0020);
        chk("preload.ir_q", ir_q, 32'h01000000);
        ir_load = 1'b0;
        tick();
        chk("postload.reg_in", 32'(reg_in), 32'h0004);
        chk("postload.idx", 32'(field_idx), 32'h2);

        // Asynchronous clear mid-decode.
        ir_load = 1'b1; ir_in = 32'h0A9B8000; gra = 1'b0; r_in = 1'b0;
        tick();
        ir_load = 1'b0; gra = 1'b1; r_in = 1'b1;
        bus_src = 32'h00000003;
        tick();
        chk("pre_clear.reg_in", 32'(reg_in), 32'h0020);
        chk("pre_clear.flag", 32'(bus_conflict), 32'h1);
        #2 clear = 1'b0;
        #1;
        chk_all_zero("async_clear");
        idle_ctrl();
        bus_src = '0;
        #1 clear = 1'b1;
        tick();
        chk("after_clear.reg_in", 32'(reg_in), 32'h0);

        // Conflict monitor sequence.
        bus_src = 32'h00000000;
        tick();
        chk("idle.flag", 32'(bus_conflict), 32'h0);
        bus_src = 32'h00000011;
        tick();
        chk("c1.flag", 32'(bus_conflict), 32'h1);
        chk("c1.src", conflict_src, 32'h00000011);
        chk("c1.cnt", 32'(conflict_cnt), 32'd1);
        bus_src = 32'h00100001;
        tick();
        chk("c2.src", conflict_src, 32'h00000011);
        chk("c2.cnt", 32'(conflict_cnt), 32'd2);
        bus_src = 32'h00800000;
        tick();
        chk("c3.flag", 32'(bus_conflict), 32'h1);
        chk("c3.src", conflict_src, 32'h00000011);
        chk("c3.cnt", 32'(conflict_cnt), 32'd2);
        bus_src = 32'h01000000;
        tick();
        chk("c4.src", conflict_src, 32'h00000011);
        chk("c4.cnt", 32'(conflict_cnt), 32'd3);

        // Clear coinciding with a new offence.
        err_clr = 1'b1; bus_src = 32'h00030000;
        tick();
        err_clr = 1'b0;
        chk("clr_hit.flag", 32'(bus_conflict), 32'h1);
        chk("clr_hit.src", conflict_src, 32'h00030000);
        chk("clr_hit.cnt", 32'(conflict_cnt), 32'd1);

        // Saturation.
        bus_src = 32'h80000000;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k == 253)
                chk("sat.cnt254", 32'(conflict_cnt), 32'd255);
        end
        chk("sat.cnt", 32'(conflict_cnt), 32'd255);
        chk("sat.src", conflict_src, 32'h00030000);

        // Plain clear with an idle bus.
        bus_src = '0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr.flag", 32'(bus_conflict), 32'h0);
        chk("clr.src", conflict_src, 32'h0);
        chk("clr.cnt", 32'(conflict_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
